// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the two-requester ALU sharing controller:
// op codes, flag bit positions and controller states.
package alu_ctrl_pkg;

  localparam int NOPS = 10;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_ADD = 4'd2,
    OP_DIV = 4'd3,
    OP_SHL = 4'd4,
    OP_NOT = 4'd5,
    OP_SUB = 4'd6,
    OP_XOR = 4'd7,
    OP_LSH = 4'd8,
    OP_RSH = 4'd9
  } op_e;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; a lone request always wins, a tie goes to
// the requester named by pointer.
module rr_arb2 (
  input  logic [1:0] request,
  input  logic       pointer,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       index
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    grant = 2'b00;
    index = 1'b0;
    if (enable) begin
      case (request)
        2'b01: begin
          grant = 2'b01;
          index = 1'b0;
        end
        2'b10: begin
          grant = 2'b10;
          index = 1'b1;
        end
        2'b11: begin
          grant = pointer ? 2'b10 : 2'b01;
          index = pointer;
        end
        default: begin
          grant = 2'b00;
          index = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one external combinational ALU between two requesters with
// round-robin grant, registered ALU inputs and per-requester chain carry.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int W    = 8,
  parameter int NOPS = alu_ctrl_pkg::NOPS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0][3:0]     req_op,
  input  logic [1:0][W-1:0]   req_a,
  input  logic [1:0][W-1:0]   req_b,
  input  logic [1:0]          req_chain,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [W-1:0]        rsp_result,
  output logic [3:0]          rsp_flags,
  output logic                rsp_err,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  output logic                alu_flag_in,
  output logic [3:0]          alu_control,
  input  logic [W-1:0]        alu_result,
  input  logic [3:0]          alu_flags
);

  localparam logic [4:0] OP_LIMIT = 5'(NOPS);

  state_e     state_q, state_d;
  logic [1:0] grant;
  logic       grant_idx;
  logic       g_q;
  logic       err_q;
  logic       rr_q;
  logic [1:0] carry_q;
  logic       handshake;

  rr_arb2 u_arb (
    .request (req_valid),
    .pointer (rr_q),
    .enable  (state_q == IDLE),
    .grant   (grant),
    .index   (grant_idx)
  );

  assign req_ready = grant;
  assign rsp_valid = (state_q == RESP) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
  assign handshake = (state_q == RESP) && rsp_ready[g_q];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment only.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|grant) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU inputs only change on accept, so the ALU sees stable operands in
  // EXEC and nothing toggles while a response waits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_q         <= 1'b0;
      err_q       <= 1'b0;
      rr_q        <= 1'b0;
      carry_q     <= 2'b00;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      alu_flag_in <= 1'b0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      if (state_q == IDLE && |grant) begin
        g_q         <= grant_idx;
        alu_a       <= req_a[grant_idx];
        alu_b       <= req_b[grant_idx];
        alu_control <= req_op[grant_idx];
        alu_flag_in <= req_chain[grant_idx] & carry_q[grant_idx];
        err_q       <= ({1'b0, req_op[grant_idx]} >= OP_LIMIT);
      end
      if (state_q == EXEC) begin
        rsp_result <= err_q ? '0 : alu_result;
        rsp_flags  <= err_q ? '0 : alu_flags;
        rsp_err    <= err_q;
      end
      if (handshake) begin
        if (!err_q) carry_q[g_q] <= rsp_flags[FLG_C];
        rr_q <= ~g_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a small behavioural ALU attached
// to the alu_* port group.
module tb_alu_share_ctrl;

  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0][3:0]  req_op = '0;
  logic [1:0][W-1:0] req_a = '0;
  logic [1:0][W-1:0] req_b = '0;
  logic [1:0]       req_chain = '0;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready = '0;
  logic [W-1:0]     rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_err;
  logic [W-1:0]     alu_a, alu_b;
  logic             alu_flag_in;
  logic [3:0]       alu_control;
  logic [W-1:0]     alu_result;
  logic [3:0]       alu_flags;

  int total = 0;
  int bad   = 0;

  alu_share_ctrl #(.W(W), .NOPS(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_chain   (req_chain),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .rsp_err     (rsp_err),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_flag_in (alu_flag_in),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; unknown codes drive garbage so forcing to zero is visible.
  always_comb begin
    logic [8:0] t;
    logic       v;
    t = 9'd0;
    v = 1'b0;
    case (alu_control)
      4'd0: t = {1'b0, alu_a & alu_b};
      4'd1: t = {1'b0, alu_a | alu_b};
      4'd2: begin
        t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_flag_in};
        v = (alu_a[7] == alu_b[7]) && (t[7] != alu_a[7]);
      end
      4'd3: t = {1'b0, (alu_b != 0) ? alu_a / alu_b : 8'd0};
      4'd4: t = {alu_a, 1'b0};
      4'd5: t = {1'b0, ~alu_a};
      4'd6: begin
        t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_flag_in};
        v = (alu_a[7] != alu_b[7]) && (t[7] != alu_a[7]);
      end
      4'd7: t = {1'b0, alu_a ^ alu_b};
      4'd8: t = {alu_a, alu_flag_in};
      4'd9: t = {alu_a[0], alu_flag_in, alu_a[7:1]};
      default: t = 9'h0EE;
    endcase
    alu_result = t[7:0];
    if (alu_control > 4'd9) alu_flags = 4'hF;
    else                    alu_flags = {t[7], t[7:0] == 8'd0, t[8], v};
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_chain = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Single-requester transaction from accept through handshake.
  task automatic run_op(input string tag, input int r, input logic [3:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic chain, input logic exp_fin,
                        input logic [7:0] exp_res, input logic [3:0] exp_flg,
                        input logic exp_err);
    logic [1:0] bit_r;
    bit_r = (r == 1) ? 2'b10 : 2'b01;
    req_op[r] = op;
    req_a[r] = a;
    req_b[r] = b;
    req_chain[r] = chain;
    req_valid = bit_r;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(bit_r));
    step();
    req_valid = '0;
    check({tag, "_ctrl"}, 32'(alu_control), 32'(op));
    check({tag, "_fin"}, 32'(alu_flag_in), 32'(exp_fin));
    step();
    check({tag, "_valid"}, 32'(rsp_valid), 32'(bit_r));
    check({tag, "_res"}, 32'(rsp_result), 32'(exp_res));
    check({tag, "_flg"}, 32'(rsp_flags), 32'(exp_flg));
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    rsp_ready = bit_r;
    step();
    rsp_ready = '0;
    check({tag, "_done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    rst_n = 1'b0;
    step();
    step();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_ctrl", 32'(alu_control), 32'd0);
    check("rst_alu_fin", 32'(alu_flag_in), 32'd0);
    check("rst_result", 32'(rsp_result), 32'd0);
    check("rst_flags", 32'(rsp_flags), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic ADD from requester 0
    run_op("add0", 0, 4'd2, 8'h35, 8'h11, 1'b0, 1'b0, 8'h46, 4'b0000, 1'b0);

    // Round-robin from a fresh reset (pointer = 0)
    do_reset();
    req_op[0] = 4'd7; req_a[0] = 8'h0F; req_b[0] = 8'hFF;
    req_op[1] = 4'd0; req_a[1] = 8'h3C; req_b[1] = 8'h0F;
    req_valid = 2'b11;
    #1;
    check("rr_first", 32'(req_ready), 32'b01);
    step();
    req_valid = 2'b10;
    check("rr_exec_ready", 32'(req_ready), 32'b00);
    step();
    check("rr_r0_valid", 32'(rsp_valid), 32'b01);
    check("rr_r0_res", 32'(rsp_result), 32'hF0);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    check("rr_second", 32'(req_ready), 32'b10);
    step();
    req_valid = 2'b00;
    step();
    check("rr_r1_valid", 32'(rsp_valid), 32'b10);
    check("rr_r1_res", 32'(rsp_result), 32'h0C);
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    #1;
    check("rr_third", 32'(req_ready), 32'b01);
    step();
    req_valid = 2'b00;
    step();
    check("rr_r0b_valid", 32'(rsp_valid), 32'b01);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;

    // Chained add on requester 1; requester 0 carry must stay clear
    run_op("ch1", 1, 4'd2, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b0110, 1'b0);
    run_op("ch2", 1, 4'd2, 8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 4'b0000, 1'b0);
    run_op("ch0", 0, 4'd2, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0100, 1'b0);

    // Backpressure: both requesters knock while a response is held
    req_op[0] = 4'd1; req_a[0] = 8'hA0; req_b[0] = 8'h05; req_chain[0] = 1'b0;
    req_valid = 2'b01;
    step();
    req_valid = 2'b11;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'b01);
      check("bp_res", 32'(rsp_result), 32'hA5);
      check("bp_ready", 32'(req_ready), 32'b00);
      step();
    end
    rsp_ready = 2'b01;
    #1;
    check("bp_ready_hs", 32'(req_ready), 32'b00);
    step();
    rsp_ready = 2'b00;
    check("bp_released", 32'(rsp_valid), 32'b00);
    check("bp_next_grant", 32'(req_ready), 32'b10);
    req_valid = 2'b00;
    step();

    // Illegal op with a set carry that must survive
    run_op("cset", 0, 4'd2, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b0110, 1'b0);
    run_op("ill", 0, 4'hC, 8'h12, 8'h34, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b1);
    run_op("ill_ch", 0, 4'd2, 8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 4'b0000, 1'b0);

    // Reset during EXEC, with pointer=1 and carry0=1 beforehand
    run_op("pre", 0, 4'd2, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b0110, 1'b0);
    req_op[1] = 4'd1; req_a[1] = 8'h10; req_b[1] = 8'h20; req_chain[1] = 1'b0;
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    rst_n = 1'b0;
    step();
    check("mr_valid", 32'(rsp_valid), 32'd0);
    check("mr_alu_a", 32'(alu_a), 32'd0);
    check("mr_alu_b", 32'(alu_b), 32'd0);
    check("mr_alu_ctrl", 32'(alu_control), 32'd0);
    check("mr_result", 32'(rsp_result), 32'd0);
    rst_n = 1'b1;
    step();
    check("mr_idle_valid", 32'(rsp_valid), 32'd0);
    req_op[0] = 4'd2; req_a[0] = 8'h00; req_b[0] = 8'h00; req_chain[0] = 1'b1;
    req_op[1] = 4'd0; req_chain[1] = 1'b0;
    req_valid = 2'b11;
    #1;
    check("mr_pointer", 32'(req_ready), 32'b01);
    step();
    req_valid = 2'b00;
    check("mr_carry_fin", 32'(alu_flag_in), 32'd0);
    step();
    check("mr_post_valid", 32'(rsp_valid), 32'b01);
    check("mr_post_res", 32'(rsp_result), 32'h00);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    check("mr_post_done", 32'(rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
